// File: rtl/layer_priority_mixer_if.sv
// Pixel-side bus of the layer priority mixer: layer inputs, frame strobe,
// palette write port and the mixed colour output.
interface layer_priority_mixer_if #(
  parameter int NUM_LAYERS = 9,
  parameter int IDX_W      = 3,
  parameter int RGB_W      = 4
);
  localparam int HIT_W = $clog2(NUM_LAYERS + 1);

  logic                        pix_valid;
  logic [NUM_LAYERS*IDX_W-1:0] layer_idx;
  logic [NUM_LAYERS-1:0]       layer_en;
  logic [NUM_LAYERS-1:0]       blink_mask;
  logic                        vsync;
  logic                        pal_we;
  logic [IDX_W-1:0]            pal_addr;
  logic [RGB_W-1:0]            pal_data;
  logic [RGB_W-1:0]            rgb;
  logic                        rgb_valid;
  logic [HIT_W-1:0]            hit_layer;
  logic                        blink_phase;

  modport master (
    output pix_valid, layer_idx, layer_en, blink_mask, vsync,
           pal_we, pal_addr, pal_data,
    input  rgb, rgb_valid, hit_layer, blink_phase
  );

  modport slave (
    input  pix_valid, layer_idx, layer_en, blink_mask, vsync,
           pal_we, pal_addr, pal_data,
    output rgb, rgb_valid, hit_layer, blink_phase
  );
endinterface

// File: rtl/layer_priority_mixer.sv
// Two-stage priority mixer: picks the highest-priority opaque layer (with
// frame-synchronous flash substitution) and maps it through a writable palette.
module layer_priority_mixer #(
  parameter int NUM_LAYERS = 9,
  parameter int IDX_W      = 3,
  parameter int RGB_W      = 4,
  parameter int BLINK_DIV  = 16,
  parameter int FLASH_IDX  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  layer_priority_mixer_if.slave bus
);
  localparam int HIT_W = $clog2(NUM_LAYERS + 1);
  localparam int PAL_N = 1 << IDX_W;
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [HIT_W-1:0] NO_HIT   = HIT_W'(NUM_LAYERS);
  localparam logic [IDX_W-1:0] FLASH    = IDX_W'(FLASH_IDX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  function automatic logic [RGB_W-1:0] default_color(input int i);
    logic [3:0] c;
    case (i)
      1:       c = 4'b0011;
      2:       c = 4'b0001;
      3:       c = 4'b0111;
      4:       c = 4'b0100;
      5:       c = 4'b1101;
      6:       c = 4'b0110;
      7:       c = 4'b1011;
      default: c = 4'b0000;
    endcase
    return RGB_W'(c);
  endfunction

  logic                   vsync_q, vsync_d;
  logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic                   blink_phase_q, blink_phase_d;
  logic [RGB_W-1:0]       palette_q [PAL_N];
  logic [RGB_W-1:0]       palette_d [PAL_N];
  logic [IDX_W-1:0]       win_idx_p1_q, win_idx_p1_d;
  logic [HIT_W-1:0]       win_layer_p1_q, win_layer_p1_d;
  logic                   vld_p1_q, vld_p1_d;
  logic [RGB_W-1:0]       rgb_p2_q, rgb_p2_d;
  logic [HIT_W-1:0]       hit_p2_q, hit_p2_d;
  logic                   vld_p2_q, vld_p2_d;
  logic                   vsync_rise;

  assign vsync_rise = bus.vsync & ~vsync_q;

  // Frame counter: a held-high vsync only counts on its rising edge.
  always_comb begin
    vsync_d       = bus.vsync;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (vsync_rise) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    palette_d = palette_q;
    if (bus.pal_we) palette_d[bus.pal_addr] = bus.pal_data;
  end

  // Stage 1: per-layer enable and flash substitution, then lowest-index win.
  always_comb begin
    logic [IDX_W-1:0] eff;
    logic             found;
    eff            = '0;
    found          = 1'b0;
    win_idx_p1_d   = '0;
    win_layer_p1_d = NO_HIT;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      eff = bus.layer_en[k] ? bus.layer_idx[k*IDX_W +: IDX_W] : '0;
      if (blink_phase_q && bus.blink_mask[k] && (eff != '0)) eff = FLASH;
      if (!found && (eff != '0)) begin
        found          = 1'b1;
        win_idx_p1_d   = eff;
        win_layer_p1_d = HIT_W'(k);
      end
    end
    // Blanked cycles carry a clean "no winner" so undriven layers never leak.
    if (!bus.pix_valid) begin
      win_idx_p1_d   = '0;
      win_layer_p1_d = NO_HIT;
    end
    vld_p1_d = bus.pix_valid;
  end

  // Stage 2: palette lookup reads the pre-write contents on a same-edge write.
  always_comb begin
    rgb_p2_d = vld_p1_q ? palette_q[win_idx_p1_q] : '0;
    hit_p2_d = vld_p1_q ? win_layer_p1_q : NO_HIT;
    vld_p2_d = vld_p1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q        <= 1'b0;
      frame_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      for (int i = 0; i < PAL_N; i++) palette_q[i] <= default_color(i);
      win_idx_p1_q   <= '0;
      win_layer_p1_q <= NO_HIT;
      vld_p1_q       <= 1'b0;
      rgb_p2_q       <= '0;
      hit_p2_q       <= NO_HIT;
      vld_p2_q       <= 1'b0;
    end else begin
      vsync_q        <= vsync_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_phase_q  <= blink_phase_d;
      palette_q      <= palette_d;
      win_idx_p1_q   <= win_idx_p1_d;
      win_layer_p1_q <= win_layer_p1_d;
      vld_p1_q       <= vld_p1_d;
      rgb_p2_q       <= rgb_p2_d;
      hit_p2_q       <= hit_p2_d;
      vld_p2_q       <= vld_p2_d;
    end
  end

  assign bus.rgb         = rgb_p2_q;
  assign bus.rgb_valid   = vld_p2_q;
  assign bus.hit_layer   = hit_p2_q;
  assign bus.blink_phase = blink_phase_q;
endmodule

// File: tb/tb_layer_priority_mixer.sv
// Directed and randomized bench for layer_priority_mixer against a
// cycle-level reference model of the priority/palette/blink rules.
module tb_layer_priority_mixer;
  localparam int NL = 9;
  localparam int IW = 3;
  localparam int RW = 4;
  localparam int BD = 2;
  localparam int FL = 3;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  layer_priority_mixer_if #(.NUM_LAYERS(NL), .IDX_W(IW), .RGB_W(RW)) bus ();

  layer_priority_mixer #(
    .NUM_LAYERS(NL), .IDX_W(IW), .RGB_W(RW), .BLINK_DIV(BD), .FLASH_IDX(FL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int m_pal [8];
  int m_edges;
  bit m_vs_prev;
  bit m_vld;
  int m_idx;
  int m_layer;

  task automatic model_reset();
    int dflt [8] = '{0, 3, 1, 7, 4, 13, 6, 11};
    for (int i = 0; i < 8; i++) m_pal[i] = dflt[i];
    m_edges   = 0;
    m_vs_prev = 1'b0;
    m_vld     = 1'b0;
    m_idx     = 0;
    m_layer   = NL;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_layer(input int k, input int v);
    logic [31:0] vv;
    vv = v;
    bus.layer_idx[k*IW +: IW] = vv[IW-1:0];
  endtask

  task automatic clear_inputs();
    bus.pix_valid  = 1'b1;
    bus.layer_idx  = '0;
    bus.layer_en   = '1;
    bus.blink_mask = '0;
    bus.pal_we     = 1'b0;
    bus.pal_addr   = '0;
    bus.pal_data   = '0;
  endtask

  // One clock: predict from current inputs, advance, compare all outputs.
  task automatic step();
    int ph, widx, wl, idx, e_rgb, e_hit, e_vld, e_ph;
    ph   = (m_edges / BD) % 2;
    widx = 0;
    wl   = NL;
    if (bus.pix_valid) begin
      for (int k = 0; k < NL; k++) begin
        idx = int'(bus.layer_idx[k*IW +: IW]);
        if (wl == NL && bus.layer_en[k] && idx != 0) begin
          widx = (ph == 1 && bus.blink_mask[k]) ? FL : idx;
          wl   = k;
        end
      end
    end
    e_vld = m_vld ? 1 : 0;
    e_rgb = m_vld ? m_pal[m_idx] : 0;
    e_hit = m_vld ? m_layer : NL;
    if (bus.pal_we) m_pal[int'(bus.pal_addr)] = int'(bus.pal_data);
    if (bus.vsync && !m_vs_prev) m_edges++;
    m_vs_prev = bus.vsync;
    m_vld     = bus.pix_valid;
    m_idx     = widx;
    m_layer   = wl;
    e_ph      = (m_edges / BD) % 2;
    @(posedge clk);
    #1;
    chk("model_rgb",         32'(bus.rgb),         32'(e_rgb));
    chk("model_rgb_valid",   32'(bus.rgb_valid),   32'(e_vld));
    chk("model_hit_layer",   32'(bus.hit_layer),   32'(e_hit));
    chk("model_blink_phase", 32'(bus.blink_phase), 32'(e_ph));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
  task automatic mid_reset(input string tag);
    bus.vsync = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rgb"},         32'(bus.rgb),         32'd0);
    chk({tag, "_rgb_valid"},   32'(bus.rgb_valid),   32'd0);
    chk({tag, "_hit_layer"},   32'(bus.hit_layer),   32'd9);
    chk({tag, "_blink_phase"}, 32'(bus.blink_phase), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    bus.vsync = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rgb",         32'(bus.rgb),         32'd0);
    chk("reset_rgb_valid",   32'(bus.rgb_valid),   32'd0);
    chk("reset_hit_layer",   32'(bus.hit_layer),   32'd9);
    chk("reset_blink_phase", 32'(bus.blink_phase), 32'd0);
    rst_n = 1'b1;

    // Priority: layer 4 beats layer 8; disabling 4 exposes 8
    set_layer(4, 5);
    set_layer(8, 2);
    step(); step();
    chk("t2_rgb", 32'(bus.rgb), 32'b1101);
    chk("t2_hit", 32'(bus.hit_layer), 32'd4);
    bus.layer_en[4] = 1'b0;
    step(); step();
    chk("t2_dis_rgb", 32'(bus.rgb), 32'b0001);
    chk("t2_dis_hit", 32'(bus.hit_layer), 32'd8);

    // All transparent
    clear_inputs();
    step(); step();
    chk("t3_rgb",   32'(bus.rgb), 32'd0);
    chk("t3_hit",   32'(bus.hit_layer), 32'd9);
    chk("t3_valid", 32'(bus.rgb_valid), 32'd1);

    // Blink with BLINK_DIV=2
    set_layer(4, 5);
    bus.blink_mask[4] = 1'b1;
    bus.vsync = 1'b1; step();
    bus.vsync = 1'b0; step();
    bus.vsync = 1'b1; step();
    bus.vsync = 1'b0; step();
    step();
    chk("t4_phase_on", 32'(bus.blink_phase), 32'd1);
    chk("t4_flash_rgb", 32'(bus.rgb), 32'b0111);
    bus.vsync = 1'b1;
    repeat (5) step();
    bus.vsync = 1'b0; step();
    chk("t4_wide_once", 32'(bus.blink_phase), 32'd1);
    bus.vsync = 1'b1; step();
    bus.vsync = 1'b0; step();
    step(); step();
    chk("t4_phase_off", 32'(bus.blink_phase), 32'd0);
    chk("t4_normal_rgb", 32'(bus.rgb), 32'b1101);

    // Palette write colliding with a stage-2 read of the same entry
    clear_inputs();
    set_layer(0, 5);
    step();
    bus.pal_we = 1'b1; bus.pal_addr = 3'd5; bus.pal_data = 4'b1111;
    step();
    chk("t5_old_value", 32'(bus.rgb), 32'b1101);
    bus.pal_we = 1'b0;
    step();
    chk("t5_new_value", 32'(bus.rgb), 32'b1111);
    mid_reset("t5_reset");
    step(); step();
    chk("t5_restored", 32'(bus.rgb), 32'b1101);

    // Valid gaps
    bus.pix_valid = 1'b1; step();
    bus.pix_valid = 1'b0; step();
    chk("t6_valid_a", 32'(bus.rgb_valid), 32'd1);
    bus.pix_valid = 1'b1; step();
    chk("t6_gap_valid", 32'(bus.rgb_valid), 32'd0);
    chk("t6_gap_rgb",   32'(bus.rgb), 32'd0);
    bus.pix_valid = 1'b0; step();
    chk("t6_valid_b", 32'(bus.rgb_valid), 32'd1);
    chk("t6_rgb_b",   32'(bus.rgb), 32'b1101);

    // Randomized traffic with a mid-stream reset
    for (int n = 0; n < 400; n++) begin
      bus.pix_valid  = ($urandom_range(0, 3) != 0);
      bus.layer_idx  = NL*IW'($urandom);
      bus.layer_en   = NL'($urandom) | NL'($urandom);
      bus.blink_mask = NL'($urandom);
      if ($urandom_range(0, 3) == 0) bus.vsync = ~bus.vsync;
      bus.pal_we     = ($urandom_range(0, 7) == 0);
      bus.pal_addr   = IW'($urandom);
      bus.pal_data   = RW'($urandom);
      if (n == 200) mid_reset("t1_mid_reset");
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
